serial2parallel: RTL and testbench

SERIAL2PARALLEL -- requirements
Module: serial2parallel

---
 rtl/serial2parallel_if.sv | 41 ++++
 rtl/serial2parallel.sv | 145 ++++++++++++++
 tb/tb_serial2parallel.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/serial2parallel_if.sv
// ============================================================================
// Module   : serial2parallel_if
// Purpose  : Serial-in / parallel-out bus between a bit-stream source and the
//            deserializer. The parity_err line exists only with S2P_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial2parallel_if #(
  parameter int DATA_WIDTH = 4
);
  logic                  serin;
  logic                  start;
  logic                  ready;
  logic [DATA_WIDTH-1:0] parout;
  logic                  valid;
  logic                  busy;
  logic                  overrun;
`ifdef S2P_PARITY_EN
  logic                  parity_err;
`endif

  // master: bit-stream source and word consumer; slave: the deserializer
  modport master (
    output serin, start, ready,
    input  parout, valid, busy, overrun
`ifdef S2P_PARITY_EN
    , input parity_err
`endif
  );

  modport slave (
    input  serin, start, ready,
    output parout, valid, busy, overrun
`ifdef S2P_PARITY_EN
    , output parity_err
`endif
  );
endinterface

`default_nettype wire

// File: rtl/serial2parallel.sv
// ============================================================================
// Module   : serial2parallel
// Purpose  : MSB-first serial-to-parallel converter with valid/ready output,
//            restart on start, sticky overrun. Define S2P_PARITY_EN to add an
//            even-parity bit per frame and the parity_err flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial2parallel #(
  parameter int DATA_WIDTH = 4
) (
  input  wire logic          clk,
  input  wire logic          reset,
  serial2parallel_if.slave   bus
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(DATA_WIDTH - 1);
`ifdef S2P_PARITY_EN
  localparam int SW = DATA_WIDTH;
`else
  // The last data bit is taken straight from serin, so one bit less is stored
  localparam int SW = DATA_WIDTH - 1;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1
`ifdef S2P_PARITY_EN
    , PARITY = 2'd2
`endif
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [CW-1:0]         r_cnt;
  logic [SW-1:0]         r_shift;
  logic [DATA_WIDTH-1:0] r_parout;
  logic                  r_valid;
  logic                  r_overrun;
  logic [SW:0]           w_cat;
  logic [DATA_WIDTH-1:0] w_word;
  logic                  w_complete;
  logic                  w_load;
  logic                  w_drop;
`ifdef S2P_PARITY_EN
  logic                  r_parity_err;
  logic                  w_perr;
`endif

  assign w_cat = {r_shift, bus.serin};
`ifdef S2P_PARITY_EN
  assign w_word = r_shift;
  assign w_perr = ^w_cat;
`else
  assign w_word = w_cat;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_complete   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) w_next_state = SHIFT;
      end
      SHIFT: begin
        if (bus.start) begin
          w_next_state = SHIFT;
        end else if (r_cnt == C_LAST) begin
`ifdef S2P_PARITY_EN
          w_next_state = PARITY;
`else
          w_next_state = IDLE;
          w_complete   = 1'b1;
`endif
        end
      end
`ifdef S2P_PARITY_EN
      PARITY: begin
        if (bus.start) begin
          w_next_state = SHIFT;
        end else begin
          w_next_state = IDLE;
          w_complete   = 1'b1;
        end
      end
`endif
      default: w_next_state = IDLE;
    endcase
  end

  assign w_load = w_complete && (!r_valid || bus.ready);
  assign w_drop = w_complete && r_valid && !bus.ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt        <= '0;
      r_shift      <= '0;
      r_parout     <= '0;
      r_valid      <= 1'b0;
      r_overrun    <= 1'b0;
`ifdef S2P_PARITY_EN
      r_parity_err <= 1'b0;
`endif
    end else begin
      // start wins over everything: a restart discards any partial frame
      if (bus.start) begin
        r_cnt   <= '0;
        r_shift <= '0;
      end else if (r_state == SHIFT) begin
        r_shift <= w_cat[SW-1:0];
        r_cnt   <= (r_cnt == C_LAST) ? '0 : r_cnt + CW'(1);
      end

      if (w_load) begin
        r_parout     <= w_word;
        r_valid      <= 1'b1;
`ifdef S2P_PARITY_EN
        r_parity_err <= w_perr;
`endif
      end else if (r_valid && bus.ready) begin
        r_valid <= 1'b0;
      end

      if (w_drop) r_overrun <= 1'b1;
    end
  end

  assign bus.parout     = r_parout;
  assign bus.valid      = r_valid;
  assign bus.busy       = (r_state != IDLE);
  assign bus.overrun    = r_overrun;
`ifdef S2P_PARITY_EN
  assign bus.parity_err = r_parity_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial2parallel.sv
// ============================================================================
// Module   : tb_serial2parallel
// Purpose  : Directed self-checking bench for serial2parallel (DATA_WIDTH=4);
//            parity cases are included when S2P_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial2parallel;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  serial2parallel_if #(.DATA_WIDTH(4)) bus ();

  serial2parallel #(.DATA_WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send_bits(input logic [3:0] w, input int n);
    for (int i = 3; i > 3 - n; i--) begin
      bus.serin = w[i];
      tick();
    end
  endtask

  task automatic finish_parity(input logic [3:0] w);
`ifdef S2P_PARITY_EN
    bus.serin = ^w;
    tick();
`else
    bus.serin = w[0];
`endif
  endtask

  task automatic send_frame(input logic [3:0] w);
    start_frame();
    send_bits(w, 4);
    finish_parity(w);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b0;
    bus.serin = 1'b0;
    bus.start = 1'b0;
    bus.ready = 1'b0;

    // Reset state
    #2;
    check("rst_parout",  32'(bus.parout),  32'h0);
    check("rst_valid",   32'(bus.valid),   32'h0);
    check("rst_busy",    32'(bus.busy),    32'h0);
    check("rst_overrun", 32'(bus.overrun), 32'h0);
`ifdef S2P_PARITY_EN
    check("rst_perr",    32'(bus.parity_err), 32'h0);
`endif
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Basic frame 1011 with latency
    bus.ready = 1'b1;
    start_frame();
    check("t1_busy_after_start",  32'(bus.busy),  32'h1);
    check("t1_valid_after_start", 32'(bus.valid), 32'h0);
    send_bits(4'b1011, 3);
    check("t1_valid_early", 32'(bus.valid), 32'h0);
    bus.serin = 1'b1;
    tick();
`ifdef S2P_PARITY_EN
    check("t1_valid_before_par", 32'(bus.valid), 32'h0);
    finish_parity(4'b1011);
`endif
    check("t1_valid",  32'(bus.valid),  32'h1);
    check("t1_parout", 32'(bus.parout), 32'hB);
    check("t1_busy_done", 32'(bus.busy), 32'h0);
    tick();
    check("t1_valid_one_cycle", 32'(bus.valid),  32'h0);
    check("t1_parout_hold",     32'(bus.parout), 32'hB);

    // Back-to-back 9 then 6
    send_frame(4'h9);
    check("t2_valid9",  32'(bus.valid),  32'h1);
    check("t2_parout9", 32'(bus.parout), 32'h9);
    send_frame(4'h6);
    check("t2_valid6",   32'(bus.valid),   32'h1);
    check("t2_parout6",  32'(bus.parout),  32'h6);
    check("t2_overrun",  32'(bus.overrun), 32'h0);
    tick();
    check("t2_valid_clear", 32'(bus.valid), 32'h0);

    // Restart after two bits, then 3
    start_frame();
    send_bits(4'b1000, 2);
    start_frame();
    check("t3_busy_restart",  32'(bus.busy),  32'h1);
    check("t3_valid_restart", 32'(bus.valid), 32'h0);
    send_bits(4'h3, 3);
    check("t3_no_extra_valid", 32'(bus.valid), 32'h0);
    send_bits(4'h3 << 3, 1);
    finish_parity(4'h3);
    check("t3_valid",  32'(bus.valid),  32'h1);
    check("t3_parout", 32'(bus.parout), 32'h3);
    tick();
    tick();
    check("t3_valid_after", 32'(bus.valid), 32'h0);

    // Overrun: A held, 5 dropped
    bus.ready = 1'b0;
    send_frame(4'hA);
    tick();
    tick();
    check("t4_valid_held",  32'(bus.valid),  32'h1);
    check("t4_parout_held", 32'(bus.parout), 32'hA);
    check("t4_no_overrun",  32'(bus.overrun), 32'h0);
    send_frame(4'h5);
    check("t4_parout_kept", 32'(bus.parout),  32'hA);
    check("t4_overrun",     32'(bus.overrun), 32'h1);
    bus.ready = 1'b1;
    tick();
    check("t4_valid_drop",    32'(bus.valid),   32'h0);
    check("t4_overrun_stick", 32'(bus.overrun), 32'h1);
    tick();
    check("t4_overrun_stick2", 32'(bus.overrun), 32'h1);

    // Asynchronous reset mid-frame, then C
    start_frame();
    send_bits(4'b1100, 2);
    #3;
    reset = 1'b0;
    #1;
    check("t5_parout",  32'(bus.parout),  32'h0);
    check("t5_valid",   32'(bus.valid),   32'h0);
    check("t5_busy",    32'(bus.busy),    32'h0);
    check("t5_overrun", 32'(bus.overrun), 32'h0);
    tick();
    reset = 1'b1;
    tick();
    check("t5_idle_after_release", 32'(bus.busy), 32'h0);
    send_frame(4'hC);
    check("t5_validC",  32'(bus.valid),  32'h1);
    check("t5_paroutC", 32'(bus.parout), 32'hC);
    check("t5_overrunC", 32'(bus.overrun), 32'h0);
    tick();

`ifdef S2P_PARITY_EN
    // 1011 has three ones: parity bit 0 is a mismatch, 1 is good
    start_frame();
    send_bits(4'b1011, 4);
    bus.serin = 1'b0;
    tick();
    check("t6_perr_bad",   32'(bus.parity_err), 32'h1);
    check("t6_parout_bad", 32'(bus.parout),     32'hB);
    check("t6_valid_bad",  32'(bus.valid),      32'h1);
    start_frame();
    send_bits(4'b1011, 4);
    bus.serin = 1'b1;
    tick();
    check("t6_perr_good",  32'(bus.parity_err), 32'h0);
    check("t6_valid_good", 32'(bus.valid),      32'h1);
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
